// File: rtl/ptmch_cnt_pkg.sv
// Shared types and constants for the multi-channel trigger-pulse event counter.
package ptmch_cnt_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  localparam int unsigned NUM_CH_DEF   = 5;
  localparam int unsigned CNT_W_DEF    = 32;
  localparam int unsigned SYNC_STG_DEF = 3;

  localparam int unsigned CH_PRGEXCT = 0;
  localparam int unsigned CH_RDSTAT  = 1;
  localparam int unsigned CH_BLKERS  = 2;
  localparam int unsigned CH_PDREAD  = 3;
  localparam int unsigned CH_WRSTAT  = 4;

  function automatic logic edge_hit(input edge_sel_e mode, input logic s, input logic h);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = s & ~h;
      EDGE_FALL: hit = ~s & h;
      EDGE_BOTH: hit = s ^ h;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ptmch_cnt_ch.sv
// One trigger channel: synchroniser, edge detect, saturating counter, sticky flags.
// Threshold interrupt status exists only when PTMCH_CNT_IRQ_EN is defined.
module ptmch_cnt_ch
  import ptmch_cnt_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned SYNC_STG = SYNC_STG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trg,
  input  logic             cnt_en,
  input  edge_sel_e        edge_sel,
  input  logic             clr,
`ifdef PTMCH_CNT_IRQ_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             irq_stat,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic             sat_flag
);

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                hist_q, hist_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                edge_det;
  logic                inc;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign edge_det = edge_hit(edge_sel, sync_q[SYNC_STG-1], hist_q);

  // History follows the synchronised input even when counting is disabled,
  // so re-enabling with the input already high cannot fake a rising edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STG-2:0], trg};
    hist_d = sync_q[SYNC_STG-1];
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    inc    = 1'b0;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (&cnt_q) begin
      sat_d = 1'b1;
    end else if (edge_det && cnt_en) begin
      inc   = 1'b1;
      cnt_d = cnt_inc;
      if (&cnt_inc) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt      = cnt_q;
  assign sat_flag = sat_q;

`ifdef PTMCH_CNT_IRQ_EN
  logic irq_stat_q, irq_stat_d;

  always_comb begin
    irq_stat_d = irq_stat_q;
    if (clr) begin
      irq_stat_d = 1'b0;
    end else if (inc && (cnt_inc == thresh) && (thresh != '0)) begin
      irq_stat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_stat_q <= 1'b0;
    else        irq_stat_q <= irq_stat_d;
  end

  assign irq_stat = irq_stat_q;
`endif

endmodule

// File: rtl/ptmch_cnt_mc.sv
// Multi-channel trigger-pulse event counter with coherent all-channel snapshot.
// Optional threshold interrupt block is enabled by defining PTMCH_CNT_IRQ_EN.
module ptmch_cnt_mc
  import ptmch_cnt_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned SYNC_STG = SYNC_STG_DEF
) (
  input  logic                    CLK100M,
  input  logic                    RESET_N,
  input  logic [NUM_CH-1:0]       TRG_PLS,
  input  logic                    CNT_EN,
  input  logic [1:0]              EDGE_SEL,
  input  logic [NUM_CH-1:0]       CLR_REQ,
  input  logic                    SNAP_REQ,
`ifdef PTMCH_CNT_IRQ_EN
  input  logic [CNT_W-1:0]        THRESH,
  input  logic [NUM_CH-1:0]       IRQ_MASK,
  output logic [NUM_CH-1:0]       IRQ_STAT,
  output logic                    IRQ,
`endif
  output logic [NUM_CH*CNT_W-1:0] CNT_LIVE,
  output logic [NUM_CH*CNT_W-1:0] CNT_SNAP,
  output logic                    SNAP_VLD,
  output logic [NUM_CH-1:0]       SAT_FLAG
);

  edge_sel_e edge_sel;
  assign edge_sel = edge_sel_e'(EDGE_SEL);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ptmch_cnt_ch #(
      .CNT_W    (CNT_W),
      .SYNC_STG (SYNC_STG)
    ) u_ch (
      .clk      (CLK100M),
      .rst_n    (RESET_N),
      .trg      (TRG_PLS[i]),
      .cnt_en   (CNT_EN),
      .edge_sel (edge_sel),
      .clr      (CLR_REQ[i]),
`ifdef PTMCH_CNT_IRQ_EN
      .thresh   (THRESH),
      .irq_stat (IRQ_STAT[i]),
`endif
      .cnt      (CNT_LIVE[i*CNT_W +: CNT_W]),
      .sat_flag (SAT_FLAG[i])
    );
  end

  // Snapshot samples the registered counters, so it holds pre-update values.
  logic [NUM_CH*CNT_W-1:0] snap_q, snap_d;
  logic                    snap_vld_q, snap_vld_d;

  always_comb begin
    snap_d     = snap_q;
    snap_vld_d = SNAP_REQ;
    if (SNAP_REQ) snap_d = CNT_LIVE;
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  assign CNT_SNAP = snap_q;
  assign SNAP_VLD = snap_vld_q;

`ifdef PTMCH_CNT_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |(IRQ_STAT & IRQ_MASK);
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign IRQ = irq_q;
`endif

endmodule

// File: doc/ptmch_cnt_mc.md
Name: ptmch_cnt_mc

Overview:
Parametrised multi-channel trigger-pulse event counter. It is the successor to the fixed 5-channel, 32-bit rising-edge counter.
- Synchronises NUM_CH asynchronous trigger inputs into the CLK100M domain.
- Detects edges per a selectable mode and counts them in saturating counters.
- Adds per-channel clear, global count enable, sticky saturation flags and a coherent all-channel snapshot for register readout.
- Sits between the flash-command trigger sources and the Avalon-MM register slave.

Parameters:
NUM_CH, 5, number of trigger channels (1..16)
CNT_W, 32, counter width in bits (8..32)
SYNC_STG, 3, synchroniser flop stages per channel (>=2)

Ports:
CLK100M  input  1  system clock; all flops are posedge
RESET_N  input  1  asynchronous active-low reset; deassertion is synchronised externally
TRG_PLS  input  NUM_CH  asynchronous trigger inputs, one per channel
CNT_EN  input  1  global count enable
EDGE_SEL  input  2  edge mode: 00 rise, 01 fall, 10 both, 11 none; quasi-static
CLR_REQ  input  NUM_CH  per-channel synchronous clear pulse
SNAP_REQ  input  1  snapshot request pulse
CNT_LIVE  output  NUM_CH*CNT_W  live counters; channel i at [i*CNT_W +: CNT_W]
CNT_SNAP  output  NUM_CH*CNT_W  snapshot registers, same packing
SNAP_VLD  output  1  one-cycle pulse when CNT_SNAP is updated
SAT_FLAG  output  NUM_CH  sticky saturation flags

Behaviour:
- Reset (async, RESET_N=0) zeroes the following. Effect is immediate, including mid-count and mid-snapshot; no pending event survives reset.
  - all synchroniser and history flops
  - CNT_LIVE, CNT_SNAP, SNAP_VLD, SAT_FLAG
- Synchroniser and edge detect:
  - SYNC_STG-deep chain per channel, followed by one history flop.
  - rise = s & ~h; fall = ~s & h; both = s ^ h.
  - EDGE_SEL=11 never produces an edge.
- Latency: input set up high before edge E0 → CNT_LIVE holds the new value after edge E0+SYNC_STG.
- Input pulse width: must be at least 2 CLK100M periods to be guaranteed counted. Narrower pulses may be missed; they are never double-counted.
- Counter update per channel, in priority order:
  1. CLR_REQ[i]=1 → counter=0 and SAT_FLAG[i]=0. An edge in the same cycle is discarded.
  2. Counter == all-ones → hold. SAT_FLAG[i] stays 1.
  3. Edge detected and CNT_EN=1 → counter+1. If the result is all-ones, SAT_FLAG[i] is set in the same edge.
  4. Otherwise hold.
- CNT_EN=0: edges are discarded, not queued. The history flop still tracks the input, so re-enabling while the input is high does not create a spurious rise.
- Snapshot:
  - SNAP_REQ=1 at edge E → CNT_SNAP captures every channel's pre-update CNT_LIVE value at E.
  - SNAP_VLD=1 during the cycle after E.
  - An increment or clear at E is not visible in that snapshot.
  - Back-to-back SNAP_REQ cycles each produce a capture and a SNAP_VLD pulse.
- EDGE_SEL changes take effect on the next edge. A mode change alone never generates a count.
- Width rule: no wrap-around, ever. The counter saturates at 2^CNT_W-1.

Optional Feature:
Macro PTMCH_CNT_IRQ_EN.
- When defined, these ports are added:
  - THRESH input CNT_W: common threshold
  - IRQ_MASK input NUM_CH
  - IRQ_STAT output NUM_CH
  - IRQ output 1
- IRQ_STAT[i] behaviour:
  - sticky
  - set at the edge where channel i increments to exactly THRESH
  - cleared by CLR_REQ[i]; clear wins over a simultaneous set
  - never set by THRESH=0
- IRQ = |(IRQ_STAT & IRQ_MASK), registered, so 1 cycle after IRQ_STAT.
- Reset value of IRQ_STAT and IRQ is 0.
- Without the macro the ports and logic do not exist; the remaining behaviour is identical.

Decomposition:
- Package ptmch_cnt_pkg holds:
  - enum edge_sel_e (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE)
  - default parameter constants
  - channel index constants CH_PRGEXCT=0, CH_RDSTAT=1, CH_BLKERS=2, CH_PDREAD=3, CH_WRSTAT=4
- Sub-module ptmch_cnt_ch: one channel's synchroniser, edge detect, saturating counter, SAT_FLAG and optional IRQ_STAT.
- Top level: generate loop over NUM_CH, plus the shared snapshot register bank and SNAP_VLD.

Test Plan:
- Defaults, EDGE_SEL=00: 3 rise pulses, 4 cycles wide, on ch0 → CNT_LIVE ch0=3, others 0. First increment lands at E0+3.
- EDGE_SEL=10: 2 pulses on ch2 → count 4. EDGE_SEL=11: further pulses → count stays 4.
- CNT_W=8: 256 pulses on ch1 → holds 255, SAT_FLAG[1]=1. CLR_REQ[1] → 0, flag 0. CLR_REQ in the same cycle as an edge → 0.
- SNAP_REQ in the same cycle as a ch3 increment 6→7 → CNT_SNAP ch3=6, SNAP_VLD one cycle, CNT_LIVE=7.
- CNT_EN=0 during 5 pulses → no change. Re-enable with ch4 held high → no count until the next rise.
- PTMCH_CNT_IRQ_EN, THRESH=2, IRQ_MASK=01h: ch0 reaches 2 → IRQ_STAT[0]=1, IRQ one cycle later. RESET_N pulsed low mid-count → all outputs 0 immediately.
